// File: rtl/mem_subsys_if.sv
// mem_subsys_if: CPU, LCD and clear-engine signals of the memory subsystem
// master drives requests (CPU/LCD/clear control), slave is the memory subsystem.
// cpu_*: decoded CPU port with ready stall and rvalid read return
// lcd_*: never-stalled VRAM scan-out read port
// clr_*: VRAM fill engine start, fill byte and busy flag
interface mem_subsys_if #(
    parameter int DATA_W  = 8,
    parameter int VRAM_AW = 10
);
    logic               cpu_req;
    logic               cpu_we;
    logic [15:0]        cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic               cpu_ready;
    logic [DATA_W-1:0]  cpu_rdata;
    logic               cpu_rvalid;
    logic               lcd_req;
    logic [VRAM_AW-1:0] lcd_addr;
    logic [DATA_W-1:0]  lcd_rdata;
    logic               lcd_rvalid;
    logic               clr_start;
    logic [DATA_W-1:0]  clr_data;
    logic               clr_busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, lcd_req, lcd_addr, clr_start, clr_data,
        input  cpu_ready, cpu_rdata, cpu_rvalid, lcd_rdata, lcd_rvalid, clr_busy
    );
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, lcd_req, lcd_addr, clr_start, clr_data,
        output cpu_ready, cpu_rdata, cpu_rvalid, lcd_rdata, lcd_rvalid, clr_busy
    );
endinterface

// File: rtl/mem_subsys.sv
// mem_subsys: main RAM plus text VRAM behind one CPU port, an LCD read port and a VRAM clear engine
// MEMORY_CLK: single clock for all logic and both arrays
// reset_n: asynchronous active-low reset of control/pipeline state (array contents kept)
// bus: mem_subsys_if.slave carrying the cpu_*, lcd_* and clr_* signals
module mem_subsys #(
    parameter int          DATA_W    = 8,
    parameter int          RAM_AW    = 13,
    parameter int          VRAM_AW   = 10,
    parameter logic [15:0] VRAM_BASE = 16'hE000,
    parameter bit          OUT_REG   = 1'b1
) (
    input logic         MEMORY_CLK,
    input logic         reset_n,
    mem_subsys_if.slave bus
);
    typedef enum logic {IDLE, FILL} state_t;
    localparam logic [VRAM_AW-1:0] LAST = '1;

    logic [DATA_W-1:0]  ram  [2**RAM_AW];
    logic [DATA_W-1:0]  vram [2**VRAM_AW];
    state_t             state;
    logic [VRAM_AW-1:0] cnt;
    logic [DATA_W-1:0]  fill;
    logic               ram_hit, vram_hit, acc, rd, vram_we;
    logic [VRAM_AW-1:0] cpu_va, vram_wa, vram_ra;
    logic [DATA_W-1:0]  vram_wd, ram_q, vram_q, c_d2, l_d2;
    logic               c_v1, l_v1, sel_ram, sel_vram, c_v2, l_v2;

    assign ram_hit  = (bus.cpu_addr >> RAM_AW) == 16'd0;
    assign vram_hit = bus.cpu_addr[15:VRAM_AW] == VRAM_BASE[15:VRAM_AW];
    assign cpu_va   = bus.cpu_addr[VRAM_AW-1:0];
    // LCD owns the VRAM read port; the clear engine owns the VRAM write port
    assign bus.cpu_ready = !(vram_hit && (bus.clr_busy || (!bus.cpu_we && bus.lcd_req)));
    assign acc      = bus.cpu_req && bus.cpu_ready;
    assign rd       = acc && !bus.cpu_we;
    assign vram_we  = bus.clr_busy || (acc && bus.cpu_we && vram_hit);
    assign vram_wa  = bus.clr_busy ? cnt : cpu_va;
    assign vram_wd  = bus.clr_busy ? fill : bus.cpu_wdata;
    assign vram_ra  = bus.lcd_req ? bus.lcd_addr : cpu_va;

    // Read-first block RAMs: the registered read sees the pre-write contents
    always_ff @(posedge MEMORY_CLK) begin
        if (acc && bus.cpu_we && ram_hit) ram[bus.cpu_addr[RAM_AW-1:0]] <= bus.cpu_wdata;
        if (vram_we) vram[vram_wa] <= vram_wd;
        ram_q  <= ram[bus.cpu_addr[RAM_AW-1:0]];
        vram_q <= vram[vram_ra];
    end

    always_ff @(posedge MEMORY_CLK or negedge reset_n) begin
        if (!reset_n) begin
            c_v1     <= 1'b0;
            l_v1     <= 1'b0;
            sel_ram  <= 1'b0;
            sel_vram <= 1'b0;
            c_v2     <= 1'b0;
            l_v2     <= 1'b0;
            c_d2     <= '0;
            l_d2     <= '0;
        end else begin
            c_v1     <= rd;
            l_v1     <= bus.lcd_req;
            sel_ram  <= ram_hit;
            sel_vram <= vram_hit;
            c_v2     <= c_v1;
            l_v2     <= l_v1;
            if (c_v1) c_d2 <= sel_ram ? ram_q : sel_vram ? vram_q : '0;
            if (l_v1) l_d2 <= vram_q;
        end
    end

    generate
        if (OUT_REG) begin : g_out
            logic              c_v3, l_v3;
            logic [DATA_W-1:0] c_d3, l_d3;
            always_ff @(posedge MEMORY_CLK or negedge reset_n) begin
                if (!reset_n) begin
                    c_v3 <= 1'b0;
                    l_v3 <= 1'b0;
                    c_d3 <= '0;
                    l_d3 <= '0;
                end else begin
                    c_v3 <= c_v2;
                    l_v3 <= l_v2;
                    if (c_v2) c_d3 <= c_d2;
                    if (l_v2) l_d3 <= l_d2;
                end
            end
            assign bus.cpu_rvalid = c_v3;
            assign bus.cpu_rdata  = c_d3;
            assign bus.lcd_rvalid = l_v3;
            assign bus.lcd_rdata  = l_d3;
        end else begin : g_direct
            assign bus.cpu_rvalid = c_v2;
            assign bus.cpu_rdata  = c_d2;
            assign bus.lcd_rvalid = l_v2;
            assign bus.lcd_rdata  = l_d2;
        end
    endgenerate

    always_ff @(posedge MEMORY_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            fill         <= '0;
            bus.clr_busy <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.clr_start) begin
                state        <= FILL;
                cnt          <= '0;
                fill         <= bus.clr_data;
                bus.clr_busy <= 1'b1;
            end
        end else begin
            cnt <= cnt + VRAM_AW'(1);
            if (cnt == LAST) begin
                state        <= IDLE;
                bus.clr_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_subsys.sv
// tb_mem_subsys: directed self-checking bench for mem_subsys (OUT_REG=1 main instance, OUT_REG=0 latency instance)
module tb_mem_subsys;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_subsys_if bus ();
    mem_subsys_if bus0 ();

    mem_subsys dut (.MEMORY_CLK(clk), .reset_n(reset_n), .bus(bus));
    mem_subsys #(.OUT_REG(1'b0)) dut0 (.MEMORY_CLK(clk), .reset_n(reset_n), .bus(bus0));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = a;
        bus.cpu_wdata = d;
        #1;
        for (int i = 0; i < 2000 && !bus.cpu_ready; i++) step;
        step;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d, output int lat);
        lat = -1;
        d = 'x;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = a;
        #1;
        for (int i = 0; i < 2000 && !bus.cpu_ready; i++) step;
        step;
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.cpu_rvalid) begin
                d = bus.cpu_rdata;
                lat = i;
                break;
            end
            step;
        end
    endtask

    task automatic lcd_read(input logic [9:0] a, output logic [7:0] d, output int lat);
        lat = -1;
        d = 'x;
        bus.lcd_req = 1'b1;
        bus.lcd_addr = a;
        step;
        bus.lcd_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.lcd_rvalid) begin
                d = bus.lcd_rdata;
                lat = i;
                break;
            end
            step;
        end
    endtask

    task automatic test_reset;
        repeat (3) step;
        total++;
        if ({bus.cpu_ready, bus.cpu_rvalid, bus.cpu_rdata, bus.lcd_rvalid, bus.lcd_rdata, bus.clr_busy}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got=%b_%b_%h_%b_%h_%b exp=1_0_00_0_00_0", bus.cpu_ready, bus.cpu_rvalid,
                     bus.cpu_rdata, bus.lcd_rvalid, bus.lcd_rdata, bus.clr_busy);
        end
        reset_n = 1'b1;
        step;
    endtask

    task automatic test_ram_rw;
        logic [7:0] d;
        int lat;
        cpu_write(16'h0123, 8'hA5);
        cpu_read(16'h0123, d, lat);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL ram_latency got=%0d exp=2", lat);
        end
        total++;
        if (d !== 8'hA5) begin
            bad++;
            $display("FAIL ram_rdata got=%h exp=a5", d);
        end
        step;
        total++;
        if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 8'hA5}) begin
            bad++;
            $display("FAIL ram_strobe_hold got=%b_%h exp=0_a5", bus.cpu_rvalid, bus.cpu_rdata);
        end
    endtask

    task automatic test_latency0;
        bus0.cpu_req = 1'b1;
        bus0.cpu_we = 1'b1;
        bus0.cpu_addr = 16'h0123;
        bus0.cpu_wdata = 8'hC3;
        step;
        bus0.cpu_we = 1'b0;
        step;
        bus0.cpu_req = 1'b0;
        total++;
        if (bus0.cpu_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL lat0_early got=%b exp=0", bus0.cpu_rvalid);
        end
        step;
        total++;
        if ({bus0.cpu_rvalid, bus0.cpu_rdata} !== {1'b1, 8'hC3}) begin
            bad++;
            $display("FAIL lat0_data got=%b_%h exp=1_c3", bus0.cpu_rvalid, bus0.cpu_rdata);
        end
        step;
    endtask

    task automatic test_vram_same_cycle;
        logic [7:0] d;
        int lat;
        cpu_write(16'hE010, 8'h33);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 16'hE010;
        bus.cpu_wdata = 8'h41;
        bus.lcd_req = 1'b1;
        bus.lcd_addr = 10'h010;
        #1;
        total++;
        if (bus.cpu_ready !== 1'b1) begin
            bad++;
            $display("FAIL vram_write_ready got=%b exp=1", bus.cpu_ready);
        end
        step;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.lcd_req = 1'b0;
        d = 'x;
        for (int i = 0; i < 6; i++) begin
            if (bus.lcd_rvalid) begin
                d = bus.lcd_rdata;
                break;
            end
            step;
        end
        total++;
        if (d !== 8'h33) begin
            bad++;
            $display("FAIL lcd_read_first got=%h exp=33", d);
        end
        lcd_read(10'h010, d, lat);
        total++;
        if (d !== 8'h41 || lat !== 2) begin
            bad++;
            $display("FAIL lcd_new_data got=%h lat=%0d exp=41 lat=2", d, lat);
        end
    endtask

    task automatic test_arbitration;
        int lcd_cnt = 0;
        int lcd_at_cpu = -1;
        logic [7:0] cd = 'x;
        cpu_write(16'hE005, 8'h5A);
        for (int c = 0; c < 10; c++) begin
            bus.lcd_req = (c < 3);
            bus.lcd_addr = 10'(c);
            bus.cpu_req = (c <= 3);
            bus.cpu_we = 1'b0;
            bus.cpu_addr = 16'hE005;
            #1;
            if (c <= 3) begin
                total++;
                if (bus.cpu_ready !== 1'(c == 3)) begin
                    bad++;
                    $display("FAIL arb_ready c=%0d got=%b exp=%b", c, bus.cpu_ready, c == 3);
                end
            end
            step;
            if (bus.lcd_rvalid) lcd_cnt++;
            if (bus.cpu_rvalid && lcd_at_cpu < 0) begin
                lcd_at_cpu = lcd_cnt;
                cd = bus.cpu_rdata;
            end
        end
        bus.lcd_req = 1'b0;
        bus.cpu_req = 1'b0;
        total++;
        if (lcd_at_cpu !== 3 || lcd_cnt !== 3) begin
            bad++;
            $display("FAIL arb_order got=%0d/%0d exp=3/3", lcd_at_cpu, lcd_cnt);
        end
        total++;
        if (cd !== 8'h5A) begin
            bad++;
            $display("FAIL arb_cpu_data got=%h exp=5a", cd);
        end
    endtask

    task automatic test_clear;
        int busy_cnt;
        int stall_bad = 0;
        logic [7:0] d;
        int lat;
        bus.clr_start = 1'b1;
        bus.clr_data = 8'h20;
        step;
        bus.clr_start = 1'b0;
        busy_cnt = int'(bus.clr_busy);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 16'h0200;
        bus.cpu_wdata = 8'h66;
        #1;
        total++;
        if (bus.cpu_ready !== 1'b1) begin
            bad++;
            $display("FAIL clr_ram_ready got=%b exp=1", bus.cpu_ready);
        end
        step;
        busy_cnt += int'(bus.clr_busy);
        bus.cpu_addr = 16'hE000;
        bus.cpu_wdata = 8'h99;
        bus.clr_start = 1'b1;
        bus.clr_data = 8'h77;
        for (int i = 0; i < 2000 && bus.clr_busy; i++) begin
            #1;
            if (bus.cpu_ready !== 1'b0) stall_bad++;
            step;
            bus.clr_start = 1'b0;
            busy_cnt += int'(bus.clr_busy);
        end
        bus.clr_start = 1'b0;
        total++;
        if (busy_cnt !== 1024) begin
            bad++;
            $display("FAIL clr_busy_len got=%0d exp=1024", busy_cnt);
        end
        total++;
        if (stall_bad !== 0) begin
            bad++;
            $display("FAIL clr_stall got=%0d unstalled cycles exp=0", stall_bad);
        end
        #1;
        total++;
        if (bus.cpu_ready !== 1'b1) begin
            bad++;
            $display("FAIL clr_after_ready got=%b exp=1", bus.cpu_ready);
        end
        step;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        lcd_read(10'h000, d, lat);
        total++;
        if (d !== 8'h99) begin
            bad++;
            $display("FAIL clr_cpu_write_after got=%h exp=99", d);
        end
        lcd_read(10'h3FF, d, lat);
        total++;
        if (d !== 8'h20) begin
            bad++;
            $display("FAIL clr_fill_last got=%h exp=20", d);
        end
        lcd_read(10'h123, d, lat);
        total++;
        if (d !== 8'h20) begin
            bad++;
            $display("FAIL clr_fill_mid got=%h exp=20", d);
        end
        cpu_read(16'h0200, d, lat);
        total++;
        if (d !== 8'h66) begin
            bad++;
            $display("FAIL clr_ram_write got=%h exp=66", d);
        end
    endtask

    task automatic test_unmapped;
        logic [7:0] d;
        int lat;
        cpu_write(16'h0000, 8'h11);
        cpu_read(16'h8000, d, lat);
        total++;
        if (d !== 8'h00 || lat !== 2) begin
            bad++;
            $display("FAIL unmapped_read got=%h lat=%0d exp=00 lat=2", d, lat);
        end
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 16'h8000;
        bus.cpu_wdata = 8'hFF;
        #1;
        total++;
        if (bus.cpu_ready !== 1'b1) begin
            bad++;
            $display("FAIL unmapped_ready got=%b exp=1", bus.cpu_ready);
        end
        step;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        cpu_read(16'h0000, d, lat);
        total++;
        if (d !== 8'h11) begin
            bad++;
            $display("FAIL unmapped_ram_intact got=%h exp=11", d);
        end
        cpu_read(16'hE000, d, lat);
        total++;
        if (d !== 8'h99) begin
            bad++;
            $display("FAIL unmapped_vram_intact got=%h exp=99", d);
        end
        lcd_read(10'h000, d, lat);
    endtask

    task automatic test_reset_mid_clear;
        logic [7:0] d;
        int lat;
        logic rv = 1'b0;
        bus.clr_start = 1'b1;
        bus.clr_data = 8'h55;
        step;
        bus.clr_start = 1'b0;
        repeat (99) step;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 16'h0123;
        bus.lcd_req = 1'b1;
        bus.lcd_addr = 10'h003;
        step;
        bus.cpu_req = 1'b0;
        bus.lcd_req = 1'b0;
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.clr_busy, bus.cpu_rvalid, bus.cpu_rdata, bus.lcd_rvalid, bus.lcd_rdata}
            !== {1'b0, 1'b0, 8'h00, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL midclr_reset_out got=%b_%b_%h_%b_%h exp=0_0_00_0_00", bus.clr_busy, bus.cpu_rvalid,
                     bus.cpu_rdata, bus.lcd_rvalid, bus.lcd_rdata);
        end
        repeat (2) begin
            step;
            rv |= bus.cpu_rvalid | bus.lcd_rvalid;
        end
        reset_n = 1'b1;
        repeat (4) begin
            step;
            rv |= bus.cpu_rvalid | bus.lcd_rvalid;
        end
        total++;
        if (rv !== 1'b0) begin
            bad++;
            $display("FAIL midclr_flush got=%b exp=0", rv);
        end
        lcd_read(10'h000, d, lat);
        total++;
        if (d !== 8'h55) begin
            bad++;
            $display("FAIL midclr_addr0 got=%h exp=55", d);
        end
        lcd_read(10'd98, d, lat);
        total++;
        if (d !== 8'h55) begin
            bad++;
            $display("FAIL midclr_addr98 got=%h exp=55", d);
        end
        lcd_read(10'd101, d, lat);
        total++;
        if (d !== 8'h20) begin
            bad++;
            $display("FAIL midclr_addr101 got=%h exp=20", d);
        end
        lcd_read(10'h3FF, d, lat);
        total++;
        if (d !== 8'h20) begin
            bad++;
            $display("FAIL midclr_addr3ff got=%h exp=20", d);
        end
    endtask

    initial begin
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        bus.lcd_req = 1'b0;
        bus.lcd_addr = '0;
        bus.clr_start = 1'b0;
        bus.clr_data = '0;
        bus0.cpu_req = 1'b0;
        bus0.cpu_we = 1'b0;
        bus0.cpu_addr = '0;
        bus0.cpu_wdata = '0;
        bus0.lcd_req = 1'b0;
        bus0.lcd_addr = '0;
        bus0.clr_start = 1'b0;
        bus0.clr_data = '0;
        test_reset;
        test_ram_rw;
        test_latency0;
        test_vram_same_cycle;
        test_arbitration;
        test_clear;
        test_unmapped;
        test_reset_mid_clear;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
